// File: rtl/neuron_threshold_scheduler.sv
// Round-robin scheduler sharing one threshold comparator among N_REQ requesters.
// Registered result slot with backpressure, per-requester refractory masking and a spike counter.
module neuron_threshold_scheduler #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8,
   parameter int RW    = 4,
   localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   cfg_we,
   input  logic [WIDTH-1:0]       cfg_thr,
   input  logic                   cfg_ge,
   input  logic [RW-1:0]          cfg_refr,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*WIDTH-1:0] req_value,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [IW-1:0]          res_id,
   output logic                   res_lt,
   output logic                   res_eq,
   output logic                   res_gt,
   output logic                   res_spike,
   output logic [15:0]            spike_cnt
);

   logic [WIDTH-1:0] cfg_thr_q;
   logic             cfg_ge_q;
   logic [RW-1:0]    cfg_refr_q;

   logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
   logic [RW-1:0]    refr_q [N_REQ];
   logic [RW-1:0]    refr_d [N_REQ];

   logic             res_valid_q, res_valid_d;
   logic [IW-1:0]    res_id_q;
   logic             res_lt_q, res_eq_q, res_gt_q, res_spike_q;
   logic [15:0]      spike_cnt_q, spike_cnt_d;

   logic [N_REQ-1:0] eligible;
   logic [IW-1:0]    rot_idx [N_REQ];
   logic [WIDTH-1:0] value_arr [N_REQ];
   logic             grant_any;
   logic [IW-1:0]    grant_idx;
   logic [WIDTH-1:0] acc_value;
   logic             slot_free, accept, handshake, spike_hs;
   logic             cmp_lt, cmp_eq, cmp_gt;

   assign slot_free = !res_valid_q || res_ready;
   assign handshake = res_valid_q && res_ready;
   assign spike_hs  = handshake && res_spike_q;

   // rot_idx[k] is the requester visited k-th in round-robin order from rr_ptr.
   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_req
         logic [IW:0] sum;
         assign sum           = {1'b0, rr_ptr_q} + (IW+1)'(gi);
         assign rot_idx[gi]   = (sum >= (IW+1)'(N_REQ)) ? IW'(sum - (IW+1)'(N_REQ)) : sum[IW-1:0];
         assign value_arr[gi] = req_value[gi*WIDTH +: WIDTH];
         assign eligible[gi]  = req_valid[gi] && (refr_q[gi] == '0);

         // A spike handshake reloads the owner's counter; otherwise count down to zero.
         assign refr_d[gi] = (spike_hs && (res_id_q == IW'(gi))) ? cfg_refr_q :
                             (refr_q[gi] != '0) ? refr_q[gi] - 1'b1 : refr_q[gi];
      end
   endgenerate

   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!grant_any && eligible[rot_idx[k]]) begin
            grant_any = 1'b1;
            grant_idx = rot_idx[k];
         end
      end
   end

   assign accept    = !rst && en && slot_free && grant_any;
   assign req_ready = accept ? (N_REQ'(1) << grant_idx) : '0;
   assign acc_value = value_arr[grant_idx];

   assign cmp_lt = acc_value <  cfg_thr_q;
   assign cmp_eq = acc_value == cfg_thr_q;
   assign cmp_gt = acc_value >  cfg_thr_q;

   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      res_valid_d = res_valid_q;
      spike_cnt_d = spike_cnt_q;
      if (accept) begin
         rr_ptr_d    = (grant_idx == IW'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
         res_valid_d = 1'b1;
      end else if (handshake) begin
         res_valid_d = 1'b0;
      end
      if (spike_hs && (spike_cnt_q != 16'hFFFF)) begin
         spike_cnt_d = spike_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_thr_q   <= '1;
         cfg_ge_q    <= 1'b0;
         cfg_refr_q  <= '0;
         rr_ptr_q    <= '0;
         res_valid_q <= 1'b0;
         res_id_q    <= '0;
         res_lt_q    <= 1'b0;
         res_eq_q    <= 1'b0;
         res_gt_q    <= 1'b0;
         res_spike_q <= 1'b0;
         spike_cnt_q <= '0;
         for (int i = 0; i < N_REQ; i++) refr_q[i] <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         res_valid_q <= res_valid_d;
         spike_cnt_q <= spike_cnt_d;
         for (int i = 0; i < N_REQ; i++) refr_q[i] <= refr_d[i];
         // The compare uses the configuration already in force; a same-cycle write lands afterwards.
         if (accept) begin
            res_id_q    <= grant_idx;
            res_lt_q    <= cmp_lt;
            res_eq_q    <= cmp_eq;
            res_gt_q    <= cmp_gt;
            res_spike_q <= cmp_gt | (cfg_ge_q & cmp_eq);
         end
         if (cfg_we) begin
            cfg_thr_q  <= cfg_thr;
            cfg_ge_q   <= cfg_ge;
            cfg_refr_q <= cfg_refr;
         end
      end
   end

   assign res_valid = res_valid_q;
   assign res_id    = res_id_q;
   assign res_lt    = res_lt_q;
   assign res_eq    = res_eq_q;
   assign res_gt    = res_gt_q;
   assign res_spike = res_spike_q;
   assign spike_cnt = spike_cnt_q;

endmodule

// File: tb/tb_neuron_threshold_scheduler.sv
// Randomized and directed bench for neuron_threshold_scheduler against a cycle-level reference model.
module tb_neuron_threshold_scheduler;
   localparam int N = 4;

   logic        clk;
   logic        rst, en, cfg_we, cfg_ge, res_ready;
   logic [7:0]  cfg_thr;
   logic [3:0]  cfg_refr;
   logic [3:0]  req_valid;
   logic [31:0] req_value;
   logic [3:0]  req_ready;
   logic        res_valid, res_lt, res_eq, res_gt, res_spike;
   logic [1:0]  res_id;
   logic [15:0] spike_cnt;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   int m_thr, m_ge, m_refr, m_rr, m_rv, m_id, m_lt, m_eq, m_gt, m_spk, m_scnt;
   int m_cnt [N];

   neuron_threshold_scheduler #(.N_REQ(4), .WIDTH(8), .RW(4)) dut (
      .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_thr(cfg_thr),
      .cfg_ge(cfg_ge), .cfg_refr(cfg_refr), .req_valid(req_valid),
      .req_value(req_value), .req_ready(req_ready), .res_valid(res_valid),
      .res_ready(res_ready), .res_id(res_id), .res_lt(res_lt), .res_eq(res_eq),
      .res_gt(res_gt), .res_spike(res_spike), .spike_cnt(spike_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_thr = 255; m_ge = 0; m_refr = 0; m_rr = 0; m_rv = 0; m_id = 0;
      m_lt = 0; m_eq = 0; m_gt = 0; m_spk = 0; m_scnt = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
   endtask

   // One clock cycle: drive, check mid-cycle against the model, advance the model, cross the edge.
   task automatic step(input bit r, input bit e, input bit we, input int thr, input bit ge,
                       input int refr, input logic [3:0] v, input logic [31:0] vals, input bit rr);
      int g, idx, val;
      bit hs;
      logic [3:0] exp_ready;
      rst = r; en = e; cfg_we = we; cfg_thr = 8'(thr); cfg_ge = ge; cfg_refr = 4'(refr);
      req_valid = v; req_value = vals; res_ready = rr;
      #3;
      g = -1;
      if (!r && e && (!m_rv || rr)) begin
         for (int k = 0; k < N; k++) begin
            idx = (m_rr + k) % N;
            if (g < 0 && v[idx] && m_cnt[idx] == 0) g = idx;
         end
      end
      exp_ready = (g >= 0) ? 4'(1 << g) : 4'd0;
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("res_valid", 32'(res_valid), 32'(m_rv));
      if (m_rv != 0) begin
         chk("res_id", 32'(res_id), 32'(m_id));
         chk("res_lt", 32'(res_lt), 32'(m_lt));
         chk("res_eq", 32'(res_eq), 32'(m_eq));
         chk("res_gt", 32'(res_gt), 32'(m_gt));
         chk("res_spike", 32'(res_spike), 32'(m_spk));
      end
      chk("spike_cnt", 32'(spike_cnt), 32'(m_scnt));
      if (r) begin
         model_reset();
      end else begin
         hs = (m_rv != 0) && rr;
         if (hs) $display("txn id=%0d lt=%0d eq=%0d gt=%0d spike=%0d", m_id, m_lt, m_eq, m_gt, m_spk);
         for (int i = 0; i < N; i++) begin
            if (hs && m_spk != 0 && i == m_id) m_cnt[i] = m_refr;
            else if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
         end
         if (hs && m_spk != 0 && m_scnt < 65535) m_scnt++;
         if (g >= 0) begin
            val  = int'(vals[g*8 +: 8]);
            m_lt = (val < m_thr) ? 1 : 0;
            m_eq = (val == m_thr) ? 1 : 0;
            m_gt = (val > m_thr) ? 1 : 0;
            m_spk = (m_gt != 0 || (m_ge != 0 && m_eq != 0)) ? 1 : 0;
            m_rv = 1; m_id = g; m_rr = (g + 1) % N;
         end else if (hs) begin
            m_rv = 0;
         end
         if (we) begin m_thr = thr; m_ge = ge; m_refr = refr; end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] vals;
      rst = 1'b1; en = 1'b0; cfg_we = 1'b0; cfg_thr = '0; cfg_ge = 1'b0; cfg_refr = '0;
      req_valid = '0; req_value = '0; res_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      model_reset();
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_spike_cnt", 32'(spike_cnt), 32'd0);
      chk("rst_flags", 32'({res_lt, res_eq, res_gt, res_spike}), 32'd0);
      chk("rst_res_id", 32'(res_id), 32'd0);
      step(1, 1, 0, 0, 0, 0, 4'hF, 32'h0, 1);

      // Single compare at the threshold, strict then inclusive
      step(0, 0, 1, 100, 0, 0, 4'h0, 32'h0, 1);
      step(0, 1, 0, 0, 0, 0, 4'b0100, {8'd0, 8'd100, 16'd0}, 1);
      chk("eq_id", 32'(res_id), 32'd2);
      chk("eq_flag", 32'(res_eq), 32'd1);
      chk("eq_nospike", 32'(res_spike), 32'd0);
      step(0, 0, 1, 100, 1, 0, 4'h0, 32'h0, 1);
      step(0, 1, 0, 0, 0, 0, 4'b0100, {8'd0, 8'd100, 16'd0}, 1);
      chk("ge_spike", 32'(res_spike), 32'd1);
      step(0, 0, 0, 0, 0, 0, 4'h0, 32'h0, 1);

      // Fairness then backpressure with all requesters valid
      step(0, 0, 1, 50, 0, 0, 4'h0, 32'h0, 1);
      for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0, 0, 4'hF, 32'h0A141E28, 1);
      for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0, 4'hF, 32'h0A141E28, 0);
      for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0, 4'hF, 32'h0A141E28, 1);

      // Refractory: requester 1 spikes and is masked while the others are served
      step(0, 1, 1, 50, 0, 3, 4'h0, 32'h0, 1);
      for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 0, 0, 4'hF, {8'd10, 8'd10, 8'd200, 8'd10}, 1);

      // Configuration write colliding with an accept
      step(0, 1, 1, 50, 0, 0, 4'h0, 32'h0, 1);
      step(0, 1, 1, 150, 0, 0, 4'b0001, 32'd100, 1);
      chk("collide_gt", 32'(res_gt), 32'd1);
      step(0, 1, 0, 0, 0, 0, 4'b0001, 32'd100, 1);
      chk("collide_lt", 32'(res_lt), 32'd1);

      // Reset mid-run with a pending, unacknowledged result
      step(0, 1, 1, 5, 0, 0, 4'hF, 32'hFFFFFFFF, 0);
      step(0, 1, 0, 0, 0, 0, 4'hF, 32'hFFFFFFFF, 0);
      step(1, 1, 0, 0, 0, 0, 4'hF, 32'hFFFFFFFF, 0);
      chk("mid_rst_valid", 32'(res_valid), 32'd0);
      chk("mid_rst_cnt", 32'(spike_cnt), 32'd0);
      step(0, 1, 0, 0, 0, 0, 4'hF, 32'h0, 1);
      chk("mid_rst_first", 32'(res_id), 32'd0);

      // Randomized traffic
      for (int i = 0; i < 2000; i++) begin
         int thr;
         thr = int'($urandom_range(0, 255));
         vals = $urandom;
         if ($urandom_range(0, 3) == 0) vals[8*$urandom_range(0, 3) +: 8] = 8'(m_thr);
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
              ($urandom_range(0, 19) == 0), thr, 1'($urandom),
              int'($urandom_range(0, 15)), 4'($urandom), vals,
              ($urandom_range(0, 9) < 7));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
